// File: rtl/vga_fb_sched_pkg.sv
// ---------------------------------------------------------------------------
// vga_fb_sched_pkg
// Shared definitions for the VGA frame-buffer scheduler slice:
//   - fb_state_e : scheduler state (idle / fetching a frame / frame fetched)
//   - PIX_W      : RGB565 pixel width
//   - ADDR_W     : frame-buffer word address width
//   - PIX_1080P  : active pixels in one 1920x1080 frame
// ---------------------------------------------------------------------------
package vga_fb_sched_pkg;

    localparam int PIX_W     = 16;
    localparam int ADDR_W    = 21;
    localparam int PIX_1080P = 1920 * 1080;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } fb_state_e;

    typedef logic [PIX_W-1:0]  pixel_t;
    typedef logic [ADDR_W-1:0] fb_addr_t;

endpackage

// File: rtl/vga_pix_fifo.sv
// ---------------------------------------------------------------------------
// vga_pix_fifo
// Synchronous pixel prefetch FIFO with occupancy output and a flush input.
// The head word is presented combinationally on pop_data; the consumer
// registers it.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        empties the FIFO (wins over push and pop in that cycle)
//   push         write push_data (ignored when full)
//   pop          advance past the head word (ignored when empty)
//   pop_data     current head word (stale when empty)
//   level        number of stored words, 0..DEPTH
//   empty        level == 0
// ---------------------------------------------------------------------------
module vga_pix_fifo
    import vga_fb_sched_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  pixel_t           push_data,
    input  logic             pop,
    output pixel_t           pop_data,
    output logic [LVL_W-1:0] level,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    pixel_t           storage [DEPTH];
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH so non-power-of-two depths also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    // Pointer and occupancy bookkeeping; a flush simply rewinds everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Data storage needs no reset: nothing is read before it is written.
    always_ff @(posedge clk) begin
        if (do_push) storage[wr_ptr] <= push_data;
    end

    assign pop_data = storage[rd_ptr];

endmodule

// File: rtl/vga_fb_sched.sv
// ---------------------------------------------------------------------------
// vga_fb_sched
// Arbitrates a single-port frame-buffer memory between display prefetch
// reads and CPU writes, and feeds the VGA timing generator from a prefetch
// FIFO (vga_pix_fifo).
//
// Parameters: FB_BASE (frame base word address), PIX_PER_FRAME (reads per
// frame), FIFO_DEPTH (prefetch depth), LOW_WM (below this level display
// reads beat CPU writes).
//
// Ports:
//   vga_clk, sys_rst_n           pixel clock, asynchronous active-low reset
//   frame_start                  one-cycle pulse at vsync, restarts fetching
//   pix_data_req / pix_data      pixel pop request / registered pixel
//   cpu_wr_valid/ready/addr/data CPU write channel
//   mem_req/we/addr/wdata/gnt    memory request channel, held until mem_gnt
//   mem_rvalid / mem_rdata       in-order read return
//   underflow                    sticky: pixel requested with FIFO empty
//
// Build option: define VGA_FB_UNDERFLOW_CNT_EN to add underflow_cnt[15:0],
// a saturating count of underflow events cleared by reset and frame_start.
// ---------------------------------------------------------------------------
module vga_fb_sched
    import vga_fb_sched_pkg::*;
#(
    parameter logic [ADDR_W-1:0] FB_BASE       = 21'h0,
    parameter int                PIX_PER_FRAME = PIX_1080P,
    parameter int                FIFO_DEPTH    = 16,
    parameter int                LOW_WM        = 8
) (
    input  logic              vga_clk,
    input  logic              sys_rst_n,
    input  logic              frame_start,
    input  logic              pix_data_req,
    output logic [PIX_W-1:0]  pix_data,
    input  logic              cpu_wr_valid,
    output logic              cpu_wr_ready,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [PIX_W-1:0]  cpu_wr_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [PIX_W-1:0]  mem_rdata,
`ifdef VGA_FB_UNDERFLOW_CNT_EN
    output logic              underflow,
    output logic [15:0]       underflow_cnt
`else
    output logic              underflow
`endif
);

    localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
    localparam int DROP_W = LVL_W + 4;

    fb_state_e         state_q;
    fb_state_e         state_d;
    fb_addr_t          rd_addr_q;
    fb_addr_t          rd_cnt_q;
    logic [LVL_W-1:0]  inflight_q;
    logic [DROP_W-1:0] drop_q;

    logic [LVL_W-1:0]  fifo_level;
    logic              fifo_empty;
    pixel_t            fifo_head;
    logic              fifo_push;
    logic              fifo_pop;

    logic              rd_eligible;
    logic              rd_urgent;
    logic              sel_rd;
    logic              sel_wr;
    logic              rd_gnt;
    logic              rv_any_outstanding;
    logic              rv_retire;
    logic              uf_event;

    // A read may only be issued if its data is guaranteed a FIFO slot,
    // counting words already stored plus reads still on their way back.
    assign rd_eligible = (state_q == ST_FETCH) &&
                         ((int'(fifo_level) + int'(inflight_q)) < FIFO_DEPTH);
    assign rd_urgent   = rd_eligible && (int'(fifo_level) < LOW_WM);

    // Arbitration and next-state decode. The display wins while the FIFO is
    // running low; otherwise the CPU goes first and prefetch fills any idle
    // slot. The request is purely combinational so it naturally stays
    // asserted until the memory grants it. A frame_start overrides the
    // state from anywhere.
    always_comb begin
        sel_rd       = 1'b0;
        sel_wr       = 1'b0;
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = rd_addr_q;
        mem_wdata    = '0;
        cpu_wr_ready = 1'b0;
        rd_gnt       = 1'b0;

        if (sys_rst_n) begin
            if (rd_urgent) begin
                sel_rd = 1'b1;
            end else if (cpu_wr_valid) begin
                sel_wr = 1'b1;
            end else if (rd_eligible) begin
                sel_rd = 1'b1;
            end
        end

        mem_req      = sel_rd | sel_wr;
        mem_we       = sel_wr;
        mem_addr     = sel_wr ? cpu_wr_addr : rd_addr_q;
        mem_wdata    = sel_wr ? cpu_wr_data : '0;
        cpu_wr_ready = sel_wr & mem_gnt;
        rd_gnt       = sel_rd & mem_gnt;

        case (state_q)
            ST_IDLE:  state_d = ST_IDLE;
            ST_FETCH: begin
                if (rd_gnt && (rd_cnt_q == ADDR_W'(PIX_PER_FRAME - 1))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase

        if (frame_start) begin
            state_d = ST_FETCH;
        end
    end

    // State register.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read address and per-frame read count. A new frame rewinds both even
    // if a read is granted in the same cycle, since that read belongs to
    // the old frame and its data will be dropped.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_addr_q <= FB_BASE;
            rd_cnt_q  <= '0;
        end else if (frame_start) begin
            rd_addr_q <= FB_BASE;
            rd_cnt_q  <= '0;
        end else if (rd_gnt) begin
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
            rd_cnt_q  <= rd_cnt_q + ADDR_W'(1);
        end
    end

    // Returning words retire the oldest outstanding read. Words owed to a
    // previous frame are retired from the drop counter first and discarded;
    // only words of the current frame reach the FIFO.
    assign rv_any_outstanding = (drop_q != '0) || (inflight_q != '0);
    assign rv_retire          = mem_rvalid && (drop_q == '0) && (inflight_q != '0);
    assign fifo_push          = mem_rvalid && !frame_start && (drop_q == '0);

    // On frame_start every read still outstanding (including one granted
    // this very cycle) moves to the drop counter, less a word returning
    // now, which is itself dropped.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            inflight_q <= '0;
            drop_q     <= '0;
        end else if (frame_start) begin
            inflight_q <= '0;
            drop_q     <= drop_q + DROP_W'(inflight_q) + DROP_W'(rd_gnt)
                          - DROP_W'(mem_rvalid && rv_any_outstanding);
        end else begin
            if (mem_rvalid && (drop_q != '0)) begin
                drop_q <= drop_q - DROP_W'(1);
            end
            case ({rd_gnt, rv_retire})
                2'b10:   inflight_q <= inflight_q + LVL_W'(1);
                2'b01:   inflight_q <= inflight_q - LVL_W'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    assign fifo_pop = pix_data_req & ~fifo_empty;
    assign uf_event = pix_data_req & fifo_empty;

    vga_pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk       (vga_clk),
        .rst_n     (sys_rst_n),
        .flush     (frame_start),
        .push      (fifo_push),
        .push_data (mem_rdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .level     (fifo_level),
        .empty     (fifo_empty)
    );

    // Pixel output register: updated only on a request, black on an empty
    // FIFO. The underflow flag is sticky for the frame; a new frame starts
    // clean, so frame_start takes priority over a coincident underflow.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pix_data  <= '0;
            underflow <= 1'b0;
        end else begin
            if (pix_data_req) begin
                pix_data <= fifo_empty ? '0 : fifo_head;
            end
            if (frame_start) begin
                underflow <= 1'b0;
            end else if (uf_event) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef VGA_FB_UNDERFLOW_CNT_EN
    // Saturating per-frame count of underflow events.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            underflow_cnt <= '0;
        end else if (frame_start) begin
            underflow_cnt <= '0;
        end else if (uf_event && (underflow_cnt != 16'hFFFF)) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_fb_sched.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_vga_fb_sched
// Self-checking bench for vga_fb_sched. A small memory model returns
// rdata = address in order after a programmable latency. A frame-level
// reference model (expected FIFO contents as a queue, outstanding reads
// tagged with the frame that issued them) predicts arbitration, pixel
// data and the underflow flag every cycle. A per-frame read count of 64
// keeps the end-of-frame behaviour reachable in a short run.
// ---------------------------------------------------------------------------
module tb_vga_fb_sched;
    import vga_fb_sched_pkg::*;

    localparam logic [20:0] TB_BASE  = 21'h000100;
    localparam int          TB_PIX   = 64;
    localparam int          TB_DEPTH = 16;
    localparam int          TB_LWM   = 8;
    localparam logic [20:0] CPU_ADDR = 21'h1ABCD;
    localparam logic [15:0] CPU_DATA = 16'hBEEF;

    logic        vga_clk = 1'b0;
    logic        sys_rst_n;
    logic        frame_start;
    logic        pix_data_req;
    logic [15:0] pix_data;
    logic        cpu_wr_valid;
    logic        cpu_wr_ready;
    logic [20:0] cpu_wr_addr;
    logic [15:0] cpu_wr_data;
    logic        mem_req;
    logic        mem_we;
    logic [20:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        underflow;
`ifdef VGA_FB_UNDERFLOW_CNT_EN
    logic [15:0] underflow_cnt;
`endif

    always #5 vga_clk = ~vga_clk;

    vga_fb_sched #(
        .FB_BASE       (TB_BASE),
        .PIX_PER_FRAME (TB_PIX),
        .FIFO_DEPTH    (TB_DEPTH),
        .LOW_WM        (TB_LWM)
    ) dut (
        .vga_clk       (vga_clk),
        .sys_rst_n     (sys_rst_n),
        .frame_start   (frame_start),
        .pix_data_req  (pix_data_req),
        .pix_data      (pix_data),
        .cpu_wr_valid  (cpu_wr_valid),
        .cpu_wr_ready  (cpu_wr_ready),
        .cpu_wr_addr   (cpu_wr_addr),
        .cpu_wr_data   (cpu_wr_data),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
`ifdef VGA_FB_UNDERFLOW_CNT_EN
        .underflow     (underflow),
        .underflow_cnt (underflow_cnt)
`else
        .underflow     (underflow)
`endif
    );

    // Score keeping.
    int total = 0;
    int bad   = 0;

    // Reference model state.
    typedef struct {
        logic [15:0] data;
        int          frame;
        int          ready;
    } rd_ent_t;

    rd_ent_t     pend_q[$];
    logic [15:0] fifo_m[$];
    int          cur_frame = 0;
    int          cyc       = 0;
    int          reads_done = 0;
    bit          started   = 1'b0;
    int          mem_lat   = 1;
    logic [15:0] exp_pix   = 16'h0;
    bit          exp_uf    = 1'b0;
    int          exp_ucnt  = 0;

    // Comb outputs captured mid-cycle by applyStimulus.
    bit          s_req;
    bit          s_we;
    logic [20:0] s_addr;
    bit          s_ready;
    bit          s_accepted;

    // Table of directed vectors.
    typedef struct {
        bit          fs;
        bit          preq;
        bit          cwv;
        bit          gnt;
        bit          e_req;
        bit          e_we;
        logic [20:0] e_addr;
        bit          e_ready;
    } vec_t;

    vec_t vecs[$];

    // One comparison: counts it, and reports a failure with both values.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic addVec(input bit fs, input bit preq, input bit cwv, input bit gnt,
                          input bit e_req, input bit e_we, input logic [20:0] e_addr,
                          input bit e_ready);
        vec_t v;
        v.fs = fs; v.preq = preq; v.cwv = cwv; v.gnt = gnt;
        v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr; v.e_ready = e_ready;
        vecs.push_back(v);
    endtask

    // One clock cycle: drive inputs at the falling edge, predict and check
    // the combinational request mid-cycle, advance the model to the rising
    // edge, then check the registered outputs just after it.
    task automatic applyStimulus(input bit fs, input bit preq, input bit cwv,
                                 input logic [20:0] caddr, input logic [15:0] cdata,
                                 input bit gnt);
        bit      rv;
        bit      dropped;
        bit      elig;
        bit      urgent;
        bit      e_rd;
        bit      e_wr;
        bit      uf_ev;
        int      inflight;
        rd_ent_t ent;

        @(negedge vga_clk);
        frame_start  = fs;
        pix_data_req = preq;
        cpu_wr_valid = cwv;
        cpu_wr_addr  = caddr;
        cpu_wr_data  = cdata;
        mem_gnt      = gnt;
        rv           = (pend_q.size() > 0) && (pend_q[0].ready <= cyc);
        mem_rvalid   = rv;
        mem_rdata    = rv ? pend_q[0].data : 16'($urandom);
        #1;

        inflight = 0;
        foreach (pend_q[i]) if (pend_q[i].frame == cur_frame) inflight++;
        elig   = started && (reads_done < TB_PIX) && ((fifo_m.size() + inflight) < TB_DEPTH);
        urgent = elig && (fifo_m.size() < TB_LWM);
        e_wr   = !urgent && cwv;
        e_rd   = urgent || (!cwv && elig);

        s_req   = mem_req;
        s_we    = mem_we;
        s_addr  = mem_addr;
        s_ready = cpu_wr_ready;
        s_accepted = e_wr && gnt;

        checkOutput("mem_req", 32'(mem_req), 32'(e_rd | e_wr));
        checkOutput("cpu_wr_ready", 32'(cpu_wr_ready), 32'(e_wr && gnt));
        if (e_rd || e_wr) begin
            checkOutput("mem_we", 32'(mem_we), 32'(e_wr));
            checkOutput("mem_addr", 32'(mem_addr), e_wr ? 32'(caddr) : 32'(TB_BASE + 21'(reads_done)));
        end
        if (e_wr) checkOutput("mem_wdata", 32'(mem_wdata), 32'(cdata));

        // Memory return: old-frame words and words arriving with frame_start are lost.
        dropped = 1'b1;
        if (rv) begin
            ent = pend_q.pop_front();
            dropped = fs || (ent.frame != cur_frame);
        end
        uf_ev = 1'b0;
        if (preq) begin
            if (fifo_m.size() == 0) begin
                exp_pix = 16'h0;
                uf_ev   = 1'b1;
            end else begin
                exp_pix = fifo_m.pop_front();
            end
        end
        if (rv && !dropped) fifo_m.push_back(ent.data);
        if (e_rd && gnt) begin
            ent.data  = mem_addr[15:0];
            ent.frame = cur_frame;
            ent.ready = cyc + mem_lat;
            pend_q.push_back(ent);
            reads_done++;
        end
        if (fs) begin
            fifo_m.delete();
            cur_frame++;
            reads_done = 0;
            started    = 1'b1;
            exp_uf     = 1'b0;
            exp_ucnt   = 0;
        end else if (uf_ev) begin
            exp_uf = 1'b1;
            if (exp_ucnt < 65535) exp_ucnt++;
        end

        @(posedge vga_clk);
        #1;
        cyc++;
        checkOutput("pix_data", 32'(pix_data), 32'(exp_pix));
        checkOutput("underflow", 32'(underflow), 32'(exp_uf));
`ifdef VGA_FB_UNDERFLOW_CNT_EN
        checkOutput("underflow_cnt", 32'(underflow_cnt), 32'(exp_ucnt));
`endif
    endtask

    initial begin
        int          rd_grants;
        bit          cwv;
        logic [20:0] caddr;
        logic [15:0] cdata;
        bit          fs;

        // Directed table: start of frame, fill to full depth, then drain
        // with the memory stalled to reach level 12 and level 4.
        addVec(1, 0, 0, 1, 0, 0, '0, 0);
        for (int c = 1; c <= 16; c++) addVec(0, 0, 0, 1, 1, 0, TB_BASE + 21'(c - 1), 0);
        addVec(0, 0, 0, 1, 0, 0, '0, 0);
        addVec(0, 0, 0, 1, 0, 0, '0, 0);
        addVec(0, 1, 0, 0, 0, 0, '0, 0);
        for (int c = 0; c < 3; c++) addVec(0, 1, 0, 0, 1, 0, TB_BASE + 21'd16, 0);
        addVec(0, 0, 1, 1, 1, 1, CPU_ADDR, 1);
        for (int c = 0; c < 8; c++) addVec(0, 1, 0, 0, 1, 0, TB_BASE + 21'd16, 0);
        addVec(0, 0, 1, 1, 1, 0, TB_BASE + 21'd16, 0);

        // Reset: requests must stay quiet even with a CPU write pending.
        sys_rst_n    = 1'b0;
        frame_start  = 1'b0;
        pix_data_req = 1'b1;
        cpu_wr_valid = 1'b1;
        cpu_wr_addr  = CPU_ADDR;
        cpu_wr_data  = CPU_DATA;
        mem_gnt      = 1'b1;
        mem_rvalid   = 1'b0;
        mem_rdata    = 16'h0;
        repeat (2) @(negedge vga_clk);
        checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset_cpu_wr_ready", 32'(cpu_wr_ready), 32'd0);
        checkOutput("reset_pix_data", 32'(pix_data), 32'd0);
        checkOutput("reset_underflow", 32'(underflow), 32'd0);
        sys_rst_n    = 1'b1;
        pix_data_req = 1'b0;
        cpu_wr_valid = 1'b0;
        mem_gnt      = 1'b0;

        // Idle: no reads before the first frame_start.
        applyStimulus(0, 0, 0, CPU_ADDR, CPU_DATA, 1);
        checkOutput("idle_no_read", 32'(s_req), 32'd0);

        // Table-driven section, memory latency of one cycle.
        mem_lat = 1;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].fs, vecs[i].preq, vecs[i].cwv, CPU_ADDR, CPU_DATA, vecs[i].gnt);
            checkOutput($sformatf("vec%0d_req", i), 32'(s_req), 32'(vecs[i].e_req));
            checkOutput($sformatf("vec%0d_ready", i), 32'(s_ready), 32'(vecs[i].e_ready));
            if (vecs[i].e_req) begin
                checkOutput($sformatf("vec%0d_we", i), 32'(s_we), 32'(vecs[i].e_we));
                checkOutput($sformatf("vec%0d_addr", i), 32'(s_addr), 32'(vecs[i].e_addr));
            end
        end
        checkOutput("twelfth_pixel", 32'(pix_data), 32'(TB_BASE[15:0] + 16'd11));

        // Underflow right after a new frame: FIFO flushed, pop at level 0.
        applyStimulus(1, 0, 0, CPU_ADDR, CPU_DATA, 0);
        checkOutput("uf_cleared", 32'(underflow), 32'd0);
        applyStimulus(0, 1, 0, CPU_ADDR, CPU_DATA, 0);
        checkOutput("uf_pix_zero", 32'(pix_data), 32'd0);
        checkOutput("uf_sticky_set", 32'(underflow), 32'd1);
`ifdef VGA_FB_UNDERFLOW_CNT_EN
        checkOutput("uf_count_one", 32'(underflow_cnt), 32'd1);
`endif

        // Three reads in flight across frame_start must be discarded.
        for (int c = 0; c < 5; c++) applyStimulus(0, 0, 0, CPU_ADDR, CPU_DATA, 1);
        mem_lat = 6;
        for (int c = 0; c < 3; c++) applyStimulus(0, 0, 0, CPU_ADDR, CPU_DATA, 1);
        applyStimulus(1, 0, 0, CPU_ADDR, CPU_DATA, 0);
        mem_lat = 1;
        applyStimulus(0, 0, 0, CPU_ADDR, CPU_DATA, 1);
        for (int c = 0; c < 10; c++) applyStimulus(0, 0, 0, CPU_ADDR, CPU_DATA, 0);
        applyStimulus(0, 1, 0, CPU_ADDR, CPU_DATA, 0);
        checkOutput("first_pixel_after_drop", 32'(pix_data), 32'(TB_BASE[15:0]));

        // End of frame: exactly TB_PIX reads, then only CPU writes.
        applyStimulus(1, 0, 0, CPU_ADDR, CPU_DATA, 1);
        rd_grants = 0;
        for (int c = 0; c < 150; c++) begin
            applyStimulus(0, 1, 0, CPU_ADDR, CPU_DATA, 1);
            if (s_req && !s_we) rd_grants++;
        end
        checkOutput("reads_per_frame", 32'(rd_grants), 32'(TB_PIX));
        applyStimulus(0, 0, 1, CPU_ADDR, CPU_DATA, 1);
        checkOutput("done_write_req", 32'(s_req), 32'd1);
        checkOutput("done_write_we", 32'(s_we), 32'd1);
        checkOutput("done_write_ready", 32'(s_ready), 32'd1);
        applyStimulus(0, 0, 0, CPU_ADDR, CPU_DATA, 1);
        checkOutput("done_quiet", 32'(s_req), 32'd0);

        // Randomized traffic against the reference model.
        cwv   = 1'b0;
        caddr = CPU_ADDR;
        cdata = CPU_DATA;
        for (int c = 0; c < 4000; c++) begin
            fs      = ($urandom_range(0, 199) == 0);
            mem_lat = $urandom_range(1, 4);
            applyStimulus(fs, !fs && ($urandom_range(0, 1) == 1), cwv, caddr, cdata,
                          $urandom_range(0, 3) != 0);
            if (s_accepted || !cwv) begin
                cwv   = ($urandom_range(0, 9) < 3);
                caddr = 21'($urandom);
                cdata = 16'($urandom);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
